proc_sequencer: RTL and testbench
=================================

PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: program buffer entries, power of two, 2..16.
REQ-002 Parameter HOLD_CYCLES, default 50000000: clocks each executed result is displayed before the next fetch, at least 1.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 SW  input  4  program word to load; SW[1:0] = A and SW[3:2] = B for the operand word; one-hot opcode for instruction words.
REQ-006 KEY  input  2  KEY[0] = load strobe, KEY[1] = run/clear strobe; asynchronous, level.
REQ-007 LED  output  2  current accumulator A.
REQ-008 BUSY  output  1  high in FETCH, EXEC and HOLD.
REQ-009 DONE  output  1  high in DONE state.
REQ-010 ERR  output  1  sticky invalid-opcode flag.
REQ-011 FULL  output  1  high when the buffer holds DEPTH words.
REQ-012 PC  output  log2(DEPTH)  index of the instruction being executed.

Function
REQ-013 Each KEY bit passes a 2-flop synchronizer; an event is a 0->1 transition of the synchronized level, exactly one clock wide per press.
REQ-014 FSM states: IDLE, FETCH, EXEC, HOLD, DONE.
REQ-015 IDLE, KEY[0] event, not FULL: SW written at wr_ptr; wr_ptr and count increment by 1 next clock.
REQ-016 IDLE, KEY[0] event while FULL: ignored; buffer, count and flags unchanged.
REQ-017 Word 0 is the operand word; words 1..count-1 are instructions.
REQ-018 IDLE, KEY[1] event, count >= 2: A <= word0[1:0], B <= word0[3:2], PC <= 1, go to FETCH.
REQ-019 IDLE, KEY[1] event, count < 2: ignored.
REQ-020 IDLE, KEY[0] and KEY[1] events in the same clock: KEY[1] wins; the load is dropped.
REQ-021 FETCH: latch buffer[PC] into the instruction register, go to EXEC; exactly 1 clock.
REQ-022 EXEC, 1 clock:
- 4'b0001: A unchanged.
- 4'b0010: A <= ~A.
- 4'b0100: A <= A + B, 2-bit two's-complement, wraps (1 + 1 = -2).
- 4'b1000: A <= A & B.
- Any other value: A unchanged, ERR set.
- Then go to HOLD with hold counter 0.
REQ-023 HOLD: counter increments each clock. At HOLD_CYCLES-1, if PC = count-1 go to DONE, else PC <= PC+1 and go to FETCH.
REQ-024 LED equals A at all times; A updates are visible on LED the clock after EXEC.
REQ-025 In FETCH, EXEC and HOLD, KEY[0] and KEY[1] events are ignored.
REQ-026 DONE: A and LED hold the final value. KEY[1] event clears count, wr_ptr, PC, ERR and FULL, then goes to IDLE; A is kept. KEY[0] events are ignored.
REQ-027 Clock count from the KEY[1] event to the first EXEC update of A: synchronizer 2 + edge detection 1 + FETCH 1, with A visible the clock after EXEC.
REQ-028 FULL = (count == DEPTH); count width is log2(DEPTH)+1; wr_ptr never wraps.

Reset
REQ-029 RST asserted, in any state including mid-HOLD: asynchronously force IDLE, and set A, B, LED, PC, count, wr_ptr, hold counter, ERR, FULL, BUSY and DONE to 0, and synchronizer flops to 0.
REQ-030 Buffer contents are not reset; they are unreachable until rewritten.
REQ-031 After RST deasserts, a KEY bit already high produces no event until it goes low and then high again.

Verification (HOLD_CYCLES = 4)
REQ-032 Load 4'b0101 (A=1, B=1), then 4'b0100, then KEY[1] -> LED = 2'b10 after EXEC, DONE = 1 after 4 HOLD clocks, ERR = 0.
REQ-033 Load 4'b1101 (A=1, B=-1), then 0010, 1000, 0001 -> LED sequence 10, 10, 10, PC steps 1, 2, 3, then DONE.
REQ-034 Load operand word plus instruction 4'b0011 -> ERR = 1, LED unchanged. KEY[1] in DONE -> ERR = 0, IDLE, count = 0.
REQ-035 Press KEY[0] DEPTH+2 times -> FULL = 1 after DEPTH presses, count stays DEPTH, word 0 is unchanged.
REQ-036 Assert RST in HOLD of instruction 2 -> LED = 0, BUSY = 0, PC = 0 immediately (before the next clock edge); KEY[1] then ignored because count = 0.
REQ-037 KEY[0] and KEY[1] rise in the same clock with count = 1 -> no load, no run; count stays 1.

Source files
------------

// File: rtl/proc_sequencer.sv
// Tiny program sequencer: loads 4-bit words from switches, then runs them
// against a 2-bit accumulator, holding each result on the LEDs.
module proc_sequencer #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                     CLOCK_50,
  input  logic                     RST,
  input  logic [3:0]               SW,
  input  logic [1:0]               KEY,
  output logic [1:0]               LED,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic                     FULL,
  output logic [$clog2(DEPTH)-1:0] PC
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HOLD,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync1_q, sync2_q, prev_q, arm_q;
  logic [1:0]      vld_q;
  logic [1:0]      ev;
  logic [1:0]      a_q, a_d;
  logic [1:0]      b_q, b_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   wp_q, wp_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [3:0]      ir_q, ir_d;
  logic            err_q, err_d;
  logic            we;
  logic            full;
  logic [3:0]      mem_q [DEPTH];

  // A key must be seen low after reset before its rise counts as a press;
  // vld_q marks when sync2_q carries a real sample rather than reset zeros.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
      vld_q   <= '0;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vld_q   <= {vld_q[0], 1'b1};
      arm_q   <= arm_q | ({2{vld_q[1]}} & ~sync2_q);
    end
  end

  assign ev   = sync2_q & ~prev_q & arm_q;
  assign full = (cnt_q == DEPTH_C);

  always_ff @(posedge CLOCK_50) begin
    if (we) mem_q[wp_q[AW-1:0]] <= SW;
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      hold_q  <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      hold_q  <= hold_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wp_d    = wp_q;
    hold_d  = hold_q;
    ir_d    = ir_q;
    err_d   = err_q;
    we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ev[1]) begin
          if (cnt_q >= CW'(2)) begin
            a_d     = mem_q[0][1:0];
            b_d     = mem_q[0][3:2];
            pc_d    = AW'(1);
            state_d = S_FETCH;
          end
        end else if (ev[0] && !full) begin
          we    = 1'b1;
          wp_d  = wp_q + CW'(1);
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FETCH: begin
        ir_d    = mem_q[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (ir_q)
          4'b0001: a_d = a_q;
          4'b0010: a_d = ~a_q;
          4'b0100: a_d = a_q + b_q;
          4'b1000: a_d = a_q & b_q;
          default: err_d = 1'b1;
        endcase
        hold_d  = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          if ({1'b0, pc_q} == cnt_q - CW'(1)) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = S_FETCH;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_DONE: begin
        if (ev[1]) begin
          cnt_d   = '0;
          wp_d    = '0;
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign LED  = a_q;
  assign BUSY = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                (state_q == S_HOLD);
  assign DONE = (state_q == S_DONE);
  assign ERR  = err_q;
  assign FULL = full;
  assign PC   = pc_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: a reference accumulator model
// queues expected results at load time; the run task pops and compares them.
module tb_proc_sequencer;

  localparam int DEPTH = 8;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [1:0] key;
  logic [1:0] led;
  logic       busy, done, err, full;
  logic [2:0] pc;

  always #5 clk = ~clk;

  proc_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .CLOCK_50(clk),
    .RST     (rst),
    .SW      (sw),
    .KEY     (key),
    .LED     (led),
    .BUSY    (busy),
    .DONE    (done),
    .ERR     (err),
    .FULL    (full),
    .PC      (pc)
  );

  typedef struct packed {
    logic [2:0] pc;
    logic [1:0] led;
    logic       err;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [1:0] m_a, m_b;
  logic       m_err;
  int         n_words;

  task automatic do_reset();
    rst = 1'b1;
    key = 2'b00;
    sw  = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    sbq.delete();
    m_a = 2'b00;
    m_b = 2'b00;
    m_err = 1'b0;
    n_words = 0;
  endtask

  task automatic press_key(input int idx, input logic [3:0] w);
    @(negedge clk);
    sw = w;
    key[idx] = 1'b1;
    repeat (3) @(negedge clk);
    key[idx] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic load_word(input logic [3:0] w);
    if (n_words < DEPTH) begin
      if (n_words == 0) begin
        m_a = w[1:0];
        m_b = w[3:2];
      end else begin
        case (w)
          4'b0001: m_a = m_a;
          4'b0010: m_a = ~m_a;
          4'b0100: m_a = m_a + m_b;
          4'b1000: m_a = m_a & m_b;
          default: m_err = 1'b1;
        endcase
        sbq.push_back('{pc: 3'(n_words), led: m_a, err: m_err});
      end
      n_words++;
    end
    press_key(0, w);
  endtask

  task automatic run_program(input string name);
    int   lat;
    int   n;
    exp_t e;
    n = sbq.size();
    @(negedge clk);
    key[1] = 1'b1;
    lat = 0;
    while (!busy && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    key[1] = 1'b0;
    n_chk++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL %s start latency: got %0d clocks, want 3", name, lat);
    end
    if (busy) begin
      for (int i = 0; i < n; i++) begin
        repeat (2) @(negedge clk);
        e = sbq.pop_front();
        n_chk++;
        if ({pc, led, err} !== {e.pc, e.led, e.err}) begin
          n_fail++;
          $display("FAIL %s step %0d pc/led/err: got %0d/%b/%b want %0d/%b/%b",
                   name, i, pc, led, err, e.pc, e.led, e.err);
        end
        repeat (HOLD) @(negedge clk);
        n_chk++;
        if (i == n - 1) begin
          if ({done, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s end: got done=%b busy=%b want 1 0",
                     name, done, busy);
          end
        end else if ({busy, pc} !== {1'b1, e.pc + 3'd1}) begin
          n_fail++;
          $display("FAIL %s next fetch: got busy=%b pc=%0d want 1 %0d",
                   name, busy, pc, e.pc + 3'd1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw  = 4'b0101;
    key = 2'b01;
    #1;
    n_chk++;
    if ({led, busy, done, err, full, pc} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got led=%b b=%b d=%b e=%b f=%b pc=%0d want 0",
               led, busy, done, err, full, pc);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    key[0] = 1'b0;
    repeat (4) @(negedge clk);
    press_key(0, 4'b0100);
    press_key(1, 4'b0100);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held key after reset: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_add();
    do_reset();
    load_word(4'b0101);
    load_word(4'b0100);
    run_program("add");
    press_key(1, 4'b0000);
    n_chk++;
    if ({done, led, err, full, pc} !== {1'b0, 2'b10, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL clear: got done=%b led=%b err=%b full=%b pc=%0d want 0 10 0 0 0",
               done, led, err, full, pc);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    load_word(4'b1101);
    load_word(4'b0010);
    load_word(4'b1000);
    load_word(4'b0001);
    run_program("seq");
  endtask

  task automatic test_err();
    do_reset();
    load_word(4'b0110);
    load_word(4'b0011);
    run_program("err");
    press_key(1, 4'b0000);
    n_chk++;
    if ({err, done, led} !== {1'b0, 1'b0, 2'b10}) begin
      n_fail++;
      $display("FAIL err clear: got err=%b done=%b led=%b want 0 0 10",
               err, done, led);
    end
    press_key(1, 4'b0000);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL run after clear: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_full();
    logic [3:0] prog [DEPTH];
    prog = '{4'b0110, 4'b0100, 4'b0100, 4'b0010,
             4'b1000, 4'b0100, 4'b0010, 4'b0001};
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      load_word(prog[i]);
      n_chk++;
      if (full !== (i == DEPTH - 1)) begin
        n_fail++;
        $display("FAIL full after %0d loads: got %b want %b",
                 i + 1, full, i == DEPTH - 1);
      end
    end
    load_word(4'b0011);
    load_word(4'b0011);
    n_chk++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL full after overflow: got %b want 1", full);
    end
    run_program("full");
  endtask

  task automatic test_reset_in_hold();
    int lat;
    do_reset();
    load_word(4'b1101);
    load_word(4'b0010);
    load_word(4'b1000);
    load_word(4'b0001);
    sbq.delete();
    @(negedge clk);
    key[1] = 1'b1;
    lat = 0;
    while (!busy && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    key[1] = 1'b0;
    repeat (HOLD + 4) @(negedge clk);
    n_chk++;
    if ({busy, pc} !== {1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL hold of instr 2: got busy=%b pc=%0d want 1 2", busy, pc);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({led, busy, pc, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL async reset: got led=%b busy=%b pc=%0d done=%b want 0",
               led, busy, pc, done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    press_key(1, 4'b0000);
    n_chk++;
    if ({busy, led} !== 3'b000) begin
      n_fail++;
      $display("FAIL run after reset: got busy=%b led=%b want 0 00", busy, led);
    end
  endtask

  task automatic test_simul();
    do_reset();
    load_word(4'b0110);
    @(negedge clk);
    sw  = 4'b0010;
    key = 2'b11;
    repeat (3) @(negedge clk);
    key = 2'b00;
    repeat (4) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simultaneous keys: got busy=%b want 0", busy);
    end
    load_word(4'b0100);
    run_program("simul");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sequence();
    test_err();
    test_full();
    test_reset_in_hold();
    test_simul();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
